// File: rtl/pwm_decoder.sv
// Servo PWM pulse decoder: measures each high pulse on a servo line and
// classifies it as stop / reverse / forward / invalid, with stuck-high and
// missing-frame detection.
module pwm_decoder #(
  parameter int unsigned WIDTH_W   = 21,
  parameter int unsigned TMO_W     = 22,
  parameter int unsigned REV_MIN   = 90_000,
  parameter int unsigned REV_MAX   = 110_000,
  parameter int unsigned STOP_MIN  = 145_000,
  parameter int unsigned STOP_MAX  = 155_000,
  parameter int unsigned FWD_MIN   = 190_000,
  parameter int unsigned FWD_MAX   = 210_000,
  parameter int unsigned PULSE_MAX = 250_000,
  parameter int unsigned TIMEOUT   = 2_400_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pwm_in,
  output logic [WIDTH_W-1:0] pulse_width,
  output logic [1:0]         cmd,
  output logic               valid,
  output logic               timeout,
  output logic               error
);

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_REV  = 2'b01;
  localparam logic [1:0] CMD_FWD  = 2'b10;
  localparam logic [1:0] CMD_INV  = 2'b11;

  localparam logic [WIDTH_W-1:0] PMAX = WIDTH_W'(PULSE_MAX);
  localparam logic [TMO_W-1:0]   TMO  = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_RISE,
    HIGH
  } state_t;

  state_t             state;
  logic [1:0]         sync;
  logic               s;
  logic               s_d;
  logic               rise_p;
  logic               fall_p;
  logic [WIDTH_W-1:0] hi_cnt;
  logic [TMO_W-1:0]   frame;
  logic [TMO_W-1:0]   frame_nxt;
  logic [1:0]         cls;

  // Map a measured width onto its command class.
  function automatic logic [1:0] classify(input logic [WIDTH_W-1:0] w);
    logic [1:0] c;
    c = CMD_INV;
    if (w >= WIDTH_W'(REV_MIN) && w <= WIDTH_W'(REV_MAX))
      c = CMD_REV;
    else if (w >= WIDTH_W'(STOP_MIN) && w <= WIDTH_W'(STOP_MAX))
      c = CMD_STOP;
    else if (w >= WIDTH_W'(FWD_MIN) && w <= WIDTH_W'(FWD_MAX))
      c = CMD_FWD;
    return c;
  endfunction

  assign s = sync[1];

  // Synchronizer and registered edge strobes. The chain resets high so a line
  // that is high when reset releases is not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync   <= 2'b11;
      s_d    <= 1'b1;
      rise_p <= 1'b0;
      fall_p <= 1'b0;
    end else begin
      sync   <= {sync[0], pwm_in};
      s_d    <= s;
      rise_p <= s & ~s_d;
      fall_p <= ~s & s_d;
    end
  end

  // Classification of the running count, used at the falling edge.
  always_comb begin
    cls = classify(hi_cnt);
  end

  // Pulse measurement FSM with registered results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_LOW;
      hi_cnt      <= '0;
      pulse_width <= '0;
      cmd         <= CMD_STOP;
      valid       <= 1'b0;
      error       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        WAIT_LOW: begin
          if (!s_d) state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise_p) begin
            hi_cnt <= WIDTH_W'(1);
            state  <= HIGH;
          end
        end
        HIGH: begin
          if (hi_cnt >= PMAX) begin
            error  <= 1'b1;
            hi_cnt <= '0;
            state  <= WAIT_LOW;
          end else if (fall_p) begin
            pulse_width <= hi_cnt;
            cmd         <= cls;
            valid       <= 1'b1;
            if (cls != CMD_INV) error <= 1'b0;
            state       <= WAIT_RISE;
          end else if (s_d) begin
            hi_cnt <= hi_cnt + WIDTH_W'(1);
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

  // Frame counter: cleared by a rising edge, otherwise saturating at TIMEOUT.
  always_comb begin
    frame_nxt = frame;
    if (rise_p)
      frame_nxt = '0;
    else if (frame >= TMO)
      frame_nxt = TMO;
    else
      frame_nxt = frame + TMO_W'(1);
  end

  // Frame counter register and timeout level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame   <= '0;
      timeout <= 1'b0;
    end else begin
      frame   <= frame_nxt;
      timeout <= (frame_nxt == TMO);
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder with timing parameters scaled down by 1000.
module tb_pwm_decoder;

  localparam int unsigned WIDTH_W = 21;
  localparam int unsigned TMO     = 2400;

  logic               clk;
  logic               reset;
  logic               pwm_in;
  logic [WIDTH_W-1:0] pulse_width;
  logic [1:0]         cmd;
  logic               valid;
  logic               timeout;
  logic               error;

  typedef struct {
    int w;
    int c;
  } exp_t;

  exp_t sb[$];
  int   passes = 0;
  int   total  = 0;
  int   nvalid = 0;
  logic to_seen = 1'b0;

  pwm_decoder #(
    .WIDTH_W  (WIDTH_W),
    .TMO_W    (22),
    .REV_MIN  (90),
    .REV_MAX  (110),
    .STOP_MIN (145),
    .STOP_MAX (155),
    .FWD_MIN  (190),
    .FWD_MAX  (210),
    .PULSE_MAX(250),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .pulse_width(pulse_width),
    .cmd        (cmd),
    .valid      (valid),
    .timeout    (timeout),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input int w, input int c);
    exp_t e;
    e.w = w;
    e.c = c;
    sb.push_back(e);
  endtask

  // Called at a negedge; drives h high cycles then l low cycles.
  task automatic pulse(input int h, input int l);
    pwm_in = 1'b1;
    repeat (h) begin
      @(negedge clk);
      to_seen = to_seen | timeout;
    end
    pwm_in = 1'b0;
    repeat (l) begin
      @(negedge clk);
      to_seen = to_seen | timeout;
    end
  endtask

  // Scoreboard consumer: every valid strobe must match the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (valid === 1'b1) begin
      nvalid++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("width", 32'(pulse_width), 32'(e.w));
        chk("cmd", 32'(cmd), 32'(e.c));
      end
    end
  end

  // Global bound on run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    reset  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_width", 32'(pulse_width), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // 1: stop pulse and exact valid latency after the fall
    push(150, 0);
    pwm_in = 1'b1;
    repeat (150) @(negedge clk);
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("lat_early", 32'(valid), 32'd0);
    @(posedge clk);
    #1 chk("lat_valid", 32'(valid), 32'd1);
    @(negedge clk);
    repeat (300) @(negedge clk);

    // 2: reverse, forward and window boundaries
    push(100, 1); pulse(100, 1900);
    push(200, 2); pulse(200, 1800);
    push(110, 1); pulse(110, 300);
    push(111, 3); pulse(111, 300);
    push(90, 1);  pulse(90, 300);
    push(89, 3);  pulse(89, 300);
    push(210, 2); pulse(210, 300);

    // 3: out-of-window pulse is invalid but not an error
    push(120, 3); pulse(120, 300);
    chk("t3_error", 32'(error), 32'd0);

    // 4: stuck high sets error without a valid; a good pulse clears it
    nv = nvalid;
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    chk("stuck_error", 32'(error), 32'd1);
    chk("stuck_width_held", 32'(pulse_width), 32'd120);
    chk("stuck_cmd_held", 32'(cmd), 32'd3);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("stuck_no_valid", 32'(nvalid), 32'(nv));
    push(150, 0); pulse(150, 300);
    chk("recover_error", 32'(error), 32'd0);
    chk("recover_cmd", 32'(cmd), 32'd0);

    // 5: timeout on a silent line, clear on the next rise
    push(150, 0);
    pwm_in = 1'b1;
    repeat (150) @(negedge clk);
    pwm_in = 1'b0;
    repeat (TMO - 200) @(negedge clk);
    chk("timeout_early", 32'(timeout), 32'd0);
    repeat (60) @(negedge clk);
    chk("timeout_set", 32'(timeout), 32'd1);
    push(150, 0);
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("timeout_clear", 32'(timeout), 32'd0);
    repeat (145) @(negedge clk);
    pwm_in = 1'b0;
    repeat (TMO - 150) @(negedge clk);
    // rises spaced exactly TIMEOUT apart never raise timeout
    to_seen = 1'b0;
    push(150, 0); pulse(150, TMO - 150);
    push(150, 0); pulse(150, TMO - 150);
    chk("timeout_boundary", 32'(to_seen), 32'd0);

    // 6: reset mid-pulse discards that pulse
    pwm_in = 1'b1;
    repeat (50) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_width", 32'(pulse_width), 32'd0);
    chk("midrst_error", 32'(error), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    nv = nvalid;
    reset = 1'b1;
    repeat (50) @(negedge clk);
    pwm_in = 1'b0;
    repeat (300) @(negedge clk);
    chk("midrst_no_valid", 32'(nvalid), 32'(nv));
    push(200, 2); pulse(200, 300);
    chk("midrst_cmd", 32'(cmd), 32'd2);

    repeat (20) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
